// File: rtl/axis_uart_arbiter.sv
// Packet-aware round-robin arbiter feeding one AXI-Stream UART transmit path.
// A grant lasts from the first beat to the last beat; a beat watchdog caps grant length.
module axis_uart_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]         s_axis_valid,
    input  logic [NUM_SRC-1:0]         s_axis_last,
    output logic [NUM_SRC-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       trunc_err
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BEATS);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                         state, state_nxt;
    logic [GW-1:0]                  rr_ptr, winner, cand;
    logic [CW-1:0]                  beat_cnt;
    logic                           any_req, beat, cap_hit;
    logic [NUM_SRC-1:0][WIDTH-1:0]  src_data;

    assign src_data = s_axis_data;
    assign cap_hit  = (beat_cnt == CW'(MAX_BEATS - 1));
    assign beat     = m_axis_valid & m_axis_ready;
    assign busy     = (state == XFER);

    // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = GW'((int'(rr_ptr) + k) % NUM_SRC);
            if (s_axis_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        s_axis_ready = '0;
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        case (state)
            IDLE: if (any_req) state_nxt = XFER;
            XFER: begin
                m_axis_data            = src_data[grant_id];
                m_axis_valid           = s_axis_valid[grant_id];
                m_axis_last            = s_axis_last[grant_id] | cap_hit;
                s_axis_ready[grant_id] = m_axis_ready;
                if (m_axis_valid && m_axis_ready && m_axis_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id  <= '0;
            rr_ptr    <= GW'(NUM_SRC - 1);
            beat_cnt  <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_id <= winner;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + CW'(1);
                if (m_axis_last) rr_ptr <= grant_id;
                // Forced release: the rest of the packet comes back as a new request.
                if (cap_hit && !s_axis_last[grant_id]) trunc_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_arbiter.sv
// Randomized bench for axis_uart_arbiter: packet-level reference model feeding a beat scoreboard.
module tb_axis_uart_arbiter;

    localparam int NS = 4, W = 8, MAXB = 4, GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*W-1:0]   s_axis_data;
    logic [NS-1:0]     s_axis_valid, s_axis_last, s_axis_ready;
    logic [W-1:0]      m_axis_data;
    logic              m_axis_valid, m_axis_last, m_axis_ready;
    logic [GW-1:0]     grant_id;
    logic              busy, trunc_err;

    axis_uart_arbiter #(.NUM_SRC(NS), .WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] d; logic last; } beat_t;
    typedef struct { int src; logic [W-1:0] d; logic last; } exp_t;

    beat_t src_q[NS][$];
    exp_t  exp_q[$];

    int n_vec = 0, n_err = 0;
    int rdy_force = 1, stall_pct = 0, gap_pct = 0;
    bit idle_zero = 0;
    logic [NS-1:0] hs = '0;

    // Reference model state (packet-level) and its per-cycle expectations.
    int mo_owner, mo_ptr, mo_grant, mo_cnt, mo_nbeat = 0;
    bit mo_trunc;
    bit [NS-1:0] e_ready;
    bit e_busy, e_trunc, e_mvalid, e_last;
    bit [W-1:0] e_data;
    int e_grant;

    event req_ev;
    int   req_kind = 0;
    bit   req_ok;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mo_owner = -1; mo_ptr = NS - 1; mo_grant = 0; mo_cnt = 0; mo_trunc = 0;
        e_ready = '0; e_busy = 0; e_trunc = 0; e_mvalid = 0; e_last = 0; e_data = '0; e_grant = 0;
    endfunction

    function automatic void add_pkt(int s, int len);
        for (int j = 0; j < len; j++) src_q[s].push_back('{d: W'($urandom), last: (j == len - 1)});
    endfunction

    function automatic bit drained();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 0;
        return exp_q.size() == 0;
    endfunction

    // Expected outputs for the current cycle, then the model's move across the coming edge.
    function automatic void model_eval();
        bit found = 0;
        if (!rst) begin
            model_reset();
            exp_q.delete();
            return;
        end
        e_busy = (mo_owner >= 0); e_grant = mo_grant; e_trunc = mo_trunc;
        e_ready = '0; e_mvalid = 0; e_data = '0; e_last = 0;
        if (mo_owner < 0) begin
            for (int k = 1; k <= NS; k++) begin
                int c = (mo_ptr + k) % NS;
                if (!found && s_axis_valid[c]) begin
                    found = 1; mo_owner = c; mo_grant = c; mo_cnt = 0;
                end
            end
        end else begin
            int o = mo_owner;
            if (m_axis_ready) e_ready[o] = 1'b1;
            if (s_axis_valid[o]) begin
                e_mvalid = 1;
                e_data   = src_q[o][0].d;
                e_last   = src_q[o][0].last || (mo_cnt == MAXB - 1);
                if (m_axis_ready) begin
                    exp_q.push_back('{o, e_data, e_last});
                    mo_nbeat++;
                    if (mo_cnt == MAXB - 1 && !src_q[o][0].last) mo_trunc = 1;
                    mo_cnt++;
                    if (e_last) begin mo_ptr = o; mo_owner = -1; end
                end
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                s_axis_valid[i]      = 1'b1;
                s_axis_data[i*W +: W] = src_q[i][0].d;
                s_axis_last[i]       = src_q[i][0].last;
            end else begin
                s_axis_valid[i]      = 1'b0;
                s_axis_data[i*W +: W] = W'($urandom);
                s_axis_last[i]       = 1'($urandom_range(1));
            end
        end
        m_axis_ready = (rdy_force >= 0) ? rdy_force[0] : ($urandom_range(99) >= stall_pct);
        #1 model_eval();
    endtask

    task automatic drain(int bound);
        int c = 0;
        while (!drained() && c < bound) begin cycle(); c++; end
        repeat (2) cycle();
        req_ok = drained(); req_kind = 2; -> req_ev; #1 req_kind = 0;
    endtask

    task automatic reset_check();
        req_kind = 1; -> req_ev; #1 req_kind = 0;
    endtask

    // Monitor / scoreboard.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk or req_ev);
            if (req_kind == 1) begin
                chk("rst_s_ready", 32'(s_axis_ready), 0);
                chk("rst_m_valid", 32'(m_axis_valid), 0);
                chk("rst_m_last",  32'(m_axis_last), 0);
                chk("rst_m_data",  32'(m_axis_data), 0);
                chk("rst_busy",    32'(busy), 0);
                chk("rst_grant",   32'(grant_id), 0);
                chk("rst_trunc",   32'(trunc_err), 0);
            end else if (req_kind == 2) begin
                chk("drain_timeout", 32'(req_ok), 1);
            end else if (rst) begin
                chk("s_ready", 32'(s_axis_ready), 32'(e_ready));
                chk("busy",    32'(busy), 32'(e_busy));
                chk("grant",   32'(grant_id), 32'(e_grant));
                chk("trunc",   32'(trunc_err), 32'(e_trunc));
                chk("m_valid", 32'(m_axis_valid), 32'(e_mvalid));
                if (e_mvalid) begin
                    chk("m_data", 32'(m_axis_data), 32'(e_data));
                    chk("m_last", 32'(m_axis_last), 32'(e_last));
                end
                if (idle_zero) begin
                    chk("idle_data", 32'(m_axis_data), 0);
                    chk("idle_last", 32'(m_axis_last), 0);
                end
                if (m_axis_valid && m_axis_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 32'(m_axis_data), 32'hFFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_data", 32'(m_axis_data), 32'(e.d));
                        chk("sb_last", 32'(m_axis_last), 32'(e.last));
                        chk("sb_src",  32'(grant_id), 32'(e.src));
                    end
                end
                hs = s_axis_ready & s_axis_valid;
            end else hs = '0;
        end
    end

    initial begin
        int b0, c;
        rst = 1'b0; s_axis_valid = '0; s_axis_last = '0; s_axis_data = '0; m_axis_ready = 1'b0;
        model_reset();
        // Reset then quiet hold.
        repeat (3) @(posedge clk);
        #4 reset_check();
        @(posedge clk); #3 rst = 1'b1; idle_zero = 1;
        repeat (5) cycle();
        idle_zero = 0;

        // All four request 2-beat packets at once.
        for (int s = 0; s < NS; s++) add_pkt(s, 2);
        drain(100);

        // Sources 1 and 3 compete continuously.
        for (int p = 0; p < 4; p++) begin add_pkt(1, 3); add_pkt(3, 3); end
        drain(100);

        // Backpressure after the first beat of source 2; source 0 must wait.
        src_q[2].push_back('{8'hA5, 1'b0});
        src_q[2].push_back('{8'h5A, 1'b0});
        src_q[2].push_back('{8'hC3, 1'b1});
        b0 = mo_nbeat; c = 0;
        while (mo_nbeat == b0 && c < 20) begin cycle(); c++; end
        add_pkt(0, 2);
        rdy_force = 0;
        repeat (4) cycle();
        rdy_force = 1;
        drain(50);

        // Watchdog truncation: 6-beat packet against MAX_BEATS=4.
        add_pkt(0, 6);
        drain(50);

        // Random mix of packets, valid gaps and backpressure.
        rdy_force = -1; stall_pct = 30; gap_pct = 20;
        for (int t = 0; t < 400; t++) begin
            for (int s = 0; s < NS; s++)
                if (src_q[s].size() < 8 && $urandom_range(99) < 8) add_pkt(s, $urandom_range(1, 6));
            cycle();
        end
        rdy_force = 1; gap_pct = 0;
        drain(500);

        // Asynchronous reset on beat 2 of a 5-beat packet.
        add_pkt(2, 5);
        b0 = mo_nbeat; c = 0;
        while (mo_nbeat == b0 && c < 20) begin cycle(); c++; end
        cycle();
        #1 rst = 1'b0;
        s_axis_valid = '0;
        #1 reset_check();
        for (int s = 0; s < NS; s++) src_q[s].delete();
        exp_q.delete();
        model_reset();
        @(posedge clk); #3 rst = 1'b1;
        add_pkt(3, 2); add_pkt(2, 2); add_pkt(0, 2);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_uart_arbiter.md
Name: axis_uart_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single AXI-Stream-to-UART transmit path among NUM_SRC AXI-Stream requesters.
- Sits in front of the AXI-Stream-FIFO-UART transmitter; its master port drives that block's s_axis_* slave port.
- A grant is held from the first beat to the s_axis_last beat, so UART packets are never interleaved.
- A beat watchdog prevents a source that never sends last from locking the UART.

Parameters:
- NUM_SRC, 4, number of requesting slave ports (2..8).
- WIDTH, 8, data width per beat; must match the UART word length.
- MAX_BEATS, 64, maximum beats per grant before forced release (>=2).

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- s_axis_data  in  NUM_SRC*WIDTH  source i data at bits [i*WIDTH +: WIDTH].
- s_axis_valid  in  NUM_SRC  per-source valid.
- s_axis_last  in  NUM_SRC  per-source end-of-packet.
- s_axis_ready  out  NUM_SRC  per-source ready; at most one bit high.
- m_axis_data  out  WIDTH  to UART path s_axis_data.
- m_axis_valid  out  1  to UART path s_axis_valid.
- m_axis_last  out  1  to UART path s_axis_last.
- m_axis_ready  in  1  from UART path s_axis_ready.
- grant_id  out  clog2(NUM_SRC)  index of the current or most recent grant.
- busy  out  1  high while in XFER.
- trunc_err  out  1  sticky; set when the watchdog truncates a packet.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant_id=0, rr_ptr=NUM_SRC-1 (source 0 wins first), beat_cnt=0, busy=0, trunc_err=0, s_axis_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0.
- Reset mid-packet: the packet is abandoned with no flush; the downstream FIFO keeps any beats already written.
- FSM has two states, IDLE and XFER.
- IDLE:
  - All s_axis_ready are 0 and m_axis_valid is 0.
  - If any s_axis_valid is high, the winner is the first asserted index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  - Next edge: grant_id<=winner, beat_cnt<=0, state<=XFER.
  - Request-to-first-beat latency is exactly 1 cycle.
- XFER (datapath is combinational pass-through, no register stage):
  - m_axis_data = s_axis_data[grant_id].
  - m_axis_valid = s_axis_valid[grant_id].
  - m_axis_last = s_axis_last[grant_id] OR (beat_cnt==MAX_BEATS-1).
  - s_axis_ready[grant_id] = m_axis_ready; all other ready bits are 0.
  - A beat is m_axis_valid && m_axis_ready. Each beat increments beat_cnt.
  - A beat with m_axis_last=1 ends the grant: rr_ptr<=grant_id, state<=IDLE.
  - This gives one mandatory idle bubble cycle between packets.
- Watchdog:
  - If the beat at beat_cnt==MAX_BEATS-1 has s_axis_last=0, m_axis_last is forced to 1, trunc_err<=1, and the grant is released.
  - The remaining beats of that source's packet re-arbitrate as a new packet.
  - trunc_err clears only on reset.
- Valid deassertion by the granted source during XFER: hold the grant and wait. There is no timeout on idle cycles; only beats count.
- Requests from non-granted sources during XFER are ignored until return to IDLE. The arbiter never drops or duplicates beats.
- Backpressure: while m_axis_ready=0 (FIFO full), the grant is held and data/valid/last pass straight through, unchanged by the arbiter.
- Single requester: it is re-granted after each bubble, giving a throughput of L beats per L+1 cycles for packets of L beats.
- A 1-beat packet (valid and last on the first XFER cycle) completes in that cycle.
- busy = (state==XFER). grant_id holds its value in IDLE.

Test Plan:
- Reset then hold: rst=0, then release with no valid for 5 cycles -> all outputs 0, grant_id=0, busy=0.
- Simultaneous requests: all 4 sources assert valid with 2-beat packets, m_axis_ready=1 -> grant order 0,1,2,3, each grant 1 cycle after IDLE, downstream sees 8 beats with last on beats 2,4,6,8, and ready is never high on two sources.
- Rotation fairness: sources 1 and 3 request continuously with 3-beat packets -> grant alternates 1,3,1,3; source 1 never gets two grants in a row while 3 waits.
- Backpressure mid-packet: source 2 sends 0xA5,0x5A,0xC3(last) and m_axis_ready=0 for 4 cycles after beat 1 -> s_axis_ready[2]=0 during the stall, data stays 0x5A, output order is preserved, and no other source is granted.
- Watchdog: MAX_BEATS=4, source 0 streams 6 beats with last only on beat 6 -> m_axis_last on beat 4, trunc_err=1, then re-grant of source 0 (if it is the only requester) with last on beat 2 of the new grant.
- Async reset mid-XFER: rst=0 on beat 2 of a 5-beat packet -> outputs go to 0 immediately without waiting for clk; after release, source 0 has priority.
